// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register controller: register map and reset values.
package gpio_pkg;

    localparam int ADDR_DOUT     = 0;
    localparam int ADDR_TRI      = 1;
    localparam int ADDR_DIN      = 2;
    localparam int ADDR_RISE_EN  = 3;
    localparam int ADDR_FALL_EN  = 4;
    localparam int ADDR_IRQ_STAT = 5;
    localparam int ADDR_DOUT_SET = 6;
    localparam int ADDR_DOUT_CLR = 7;

    // Wide enough for any sane pin count; users truncate to their own width.
    localparam logic [63:0] TRI_RESET = '1;

endpackage

// File: rtl/gpio_sync.sv
// Bank of independent 2-flop synchronizers for asynchronous level inputs
// (pads, switches, buttons). Each bit is synchronized on its own.
module gpio_sync #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_meta;
    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            // NOTE: non-blocking assignments make r_sync take the old r_meta, giving two real stages.
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: output data/tristate registers for the pad
// wrapper, synchronized pad input and per-pin rise/fall edge interrupts.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_WIDTH = 16,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_wr,
    input  logic                  reg_rd,
    input  logic [ADDR_W-1:0]     reg_addr,
    input  logic [GPIO_WIDTH-1:0] reg_wdata,
    output logic [GPIO_WIDTH-1:0] reg_rdata,
    output logic                  reg_rvalid,
    output logic [GPIO_WIDTH-1:0] gpio_write,
    output logic [GPIO_WIDTH-1:0] gpio_status,
    input  logic [GPIO_WIDTH-1:0] gpio_read,
    output logic                  irq
);

    logic [GPIO_WIDTH-1:0] r_dout;
    logic [GPIO_WIDTH-1:0] r_tri;
    logic [GPIO_WIDTH-1:0] r_rise_en;
    logic [GPIO_WIDTH-1:0] r_fall_en;
    logic [GPIO_WIDTH-1:0] r_irq_stat;
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [GPIO_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_irq;

    logic [GPIO_WIDTH-1:0] w_din;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_fall;
    logic [GPIO_WIDTH-1:0] w_clr_mask;
    logic [GPIO_WIDTH-1:0] w_rdata_next;

    gpio_sync #(
        .WIDTH (GPIO_WIDTH)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (gpio_read),
        .o_sync  (w_din)
    );

    assign w_rise = w_din & ~r_prev;
    assign w_fall = ~w_din & r_prev;

    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        w_rdata_next = '0;
        case (reg_addr)
            ADDR_W'(ADDR_DOUT):     w_rdata_next = r_dout;
            ADDR_W'(ADDR_TRI):      w_rdata_next = r_tri;
            ADDR_W'(ADDR_DIN):      w_rdata_next = w_din;
            ADDR_W'(ADDR_RISE_EN):  w_rdata_next = r_rise_en;
            ADDR_W'(ADDR_FALL_EN):  w_rdata_next = r_fall_en;
            ADDR_W'(ADDR_IRQ_STAT): w_rdata_next = r_irq_stat;
            default:                w_rdata_next = '0;
        endcase
    end

    always_comb begin
        w_clr_mask = '0;
        if (reg_wr && reg_addr == ADDR_W'(ADDR_IRQ_STAT)) begin
            w_clr_mask = reg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout    <= '0;
            r_tri     <= GPIO_WIDTH'(TRI_RESET);
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (reg_wr) begin
            case (reg_addr)
                ADDR_W'(ADDR_DOUT):     r_dout    <= reg_wdata;
                ADDR_W'(ADDR_TRI):      r_tri     <= reg_wdata;
                ADDR_W'(ADDR_RISE_EN):  r_rise_en <= reg_wdata;
                ADDR_W'(ADDR_FALL_EN):  r_fall_en <= reg_wdata;
                ADDR_W'(ADDR_DOUT_SET): r_dout    <= r_dout | reg_wdata;
                ADDR_W'(ADDR_DOUT_CLR): r_dout    <= r_dout & ~reg_wdata;
                default: ;
            endcase
        end
    end

    // New edges are OR-ed in after the W1C mask, so a same-cycle edge survives its clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= '0;
            r_irq_stat <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= w_din;
            r_irq_stat <= (r_irq_stat & ~w_clr_mask) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
            r_irq      <= |r_irq_stat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= reg_rd;
            if (reg_rd) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    assign reg_rdata   = r_rdata;
    assign reg_rvalid  = r_rvalid;
    assign gpio_write  = r_dout;
    assign gpio_status = r_tri;
    assign irq         = r_irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register table, directed edge/IRQ/reset
// sequences and a randomized phase against a behavioural model.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         reg_wr;
    logic         reg_rd;
    logic [2:0]   reg_addr;
    logic [W-1:0] reg_wdata;
    logic [W-1:0] reg_rdata;
    logic         reg_rvalid;
    logic [W-1:0] gpio_write;
    logic [W-1:0] gpio_status;
    logic [W-1:0] gpio_read;
    logic         irq;

    int n_checks = 0;
    int n_err    = 0;

    gpio_ctrl #(.GPIO_WIDTH(W), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .gpio_write  (gpio_write),
        .gpio_status (gpio_status),
        .gpio_read   (gpio_read),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: register values plus the history of pad samples taken at each edge.
    logic [W-1:0] m_dout, m_tri, m_re, m_fe, m_stat, m_rdata;
    logic         m_irq, m_rvalid;
    logic [W-1:0] pad_q[$];   // [0] = newest sample, [1] = value seen by DIN, [2] = one edge older

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dout = '0; m_tri = '1; m_re = '0; m_fe = '0; m_stat = '0;
        m_rdata = '0; m_irq = 1'b0; m_rvalid = 1'b0;
        pad_q.delete();
        repeat (3) pad_q.push_back('0);
    endtask

    function automatic logic [W-1:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_dout;
            3'd1:    return m_tri;
            3'd2:    return pad_q[1];
            3'd3:    return m_re;
            3'd4:    return m_fe;
            3'd5:    return m_stat;
            default: return '0;
        endcase
    endfunction

    task automatic compare_model();
        check("gpio_write", gpio_write, m_dout);
        check("gpio_status", gpio_status, m_tri);
        check("irq", {15'b0, irq}, {15'b0, m_irq});
        check("rvalid", {15'b0, reg_rvalid}, {15'b0, m_rvalid});
        check("rdata", reg_rdata, m_rdata);
    endtask

    // One clock: predict from pre-edge inputs, let the edge happen, then compare 1 ns later.
    task automatic tick();
        logic [W-1:0] din, prev, edges_r, edges_f, clr, n_stat, n_rdata, n_dout, n_tri, n_re, n_fe, pad;
        logic         n_irq;
        din     = pad_q[1];
        prev    = pad_q[2];
        edges_r = din & ~prev;
        edges_f = ~din & prev;
        clr     = (reg_wr && reg_addr == 3'(ADDR_IRQ_STAT)) ? reg_wdata : '0;
        n_stat  = (m_stat & ~clr) | (edges_r & m_re) | (edges_f & m_fe);
        n_irq   = (m_stat != 0);
        n_rdata = reg_rd ? m_read(reg_addr) : m_rdata;
        n_dout = m_dout; n_tri = m_tri; n_re = m_re; n_fe = m_fe;
        if (reg_wr) begin
            case (reg_addr)
                3'd0: n_dout = reg_wdata;
                3'd1: n_tri  = reg_wdata;
                3'd3: n_re   = reg_wdata;
                3'd4: n_fe   = reg_wdata;
                3'd6: n_dout = m_dout | reg_wdata;
                3'd7: n_dout = m_dout & ~reg_wdata;
                default: ;
            endcase
        end
        pad = gpio_read;
        m_rvalid = reg_rd;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_dout = n_dout; m_tri = n_tri; m_re = n_re; m_fe = n_fe;
            m_stat = n_stat; m_irq = n_irq; m_rdata = n_rdata;
            pad_q.push_front(pad);
            void'(pad_q.pop_back());
        end
        #1;
        compare_model();
    endtask

    task automatic bus_op(input logic wr, input logic rd, input logic [2:0] addr, input logic [W-1:0] data);
        reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_wdata = data;
        tick();
        reg_wr = 1'b0; reg_rd = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [2:0] addr, input logic [W-1:0] exp);
        bus_op(1'b0, 1'b1, addr, '0);
        check({name, "_rvalid"}, {15'b0, reg_rvalid}, 16'h0001);
        check(name, reg_rdata, exp);
    endtask

    task automatic settle(input logic [W-1:0] pad);
        gpio_read = pad;
        repeat (4) tick();
    endtask

    typedef struct {
        logic         wr;
        logic         rd;
        logic [2:0]   addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_rdata;
        logic [W-1:0] exp_write;
        logic [W-1:0] exp_status;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [W-1:0] ext;
        logic         loopback;

        vecs[0]  = '{1'b1, 1'b0, 3'd1, 16'h00FF, 16'h0000, 16'h0000, 16'h00FF};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 16'h1234, 16'h0000, 16'h1234, 16'h00FF};
        vecs[2]  = '{1'b1, 1'b0, 3'd6, 16'h0001, 16'h0000, 16'h1235, 16'h00FF};
        vecs[3]  = '{1'b1, 1'b0, 3'd7, 16'h0030, 16'h0000, 16'h1205, 16'h00FF};
        vecs[4]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 16'h1205, 16'h1205, 16'h00FF};
        vecs[5]  = '{1'b0, 1'b1, 3'd1, 16'h0000, 16'h00FF, 16'h1205, 16'h00FF};
        vecs[6]  = '{1'b1, 1'b0, 3'd2, 16'hFFFF, 16'h0000, 16'h1205, 16'h00FF};
        vecs[7]  = '{1'b0, 1'b1, 3'd2, 16'h0000, 16'h0000, 16'h1205, 16'h00FF};
        vecs[8]  = '{1'b1, 1'b0, 3'd3, 16'hBEEF, 16'h0000, 16'h1205, 16'h00FF};
        vecs[9]  = '{1'b0, 1'b1, 3'd3, 16'h0000, 16'hBEEF, 16'h1205, 16'h00FF};
        vecs[10] = '{1'b1, 1'b0, 3'd4, 16'h1357, 16'h0000, 16'h1205, 16'h00FF};
        vecs[11] = '{1'b0, 1'b1, 3'd4, 16'h0000, 16'h1357, 16'h1205, 16'h00FF};
        vecs[12] = '{1'b0, 1'b1, 3'd6, 16'h0000, 16'h0000, 16'h1205, 16'h00FF};
        vecs[13] = '{1'b0, 1'b1, 3'd7, 16'h0000, 16'h0000, 16'h1205, 16'h00FF};
        vecs[14] = '{1'b1, 1'b1, 3'd0, 16'h00AA, 16'h1205, 16'h00AA, 16'h00FF};
        vecs[15] = '{1'b0, 1'b1, 3'd0, 16'h0000, 16'h00AA, 16'h00AA, 16'h00FF};
        vecs[16] = '{1'b0, 1'b1, 3'd5, 16'h0000, 16'h0000, 16'h00AA, 16'h00FF};

        rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0; gpio_read = '0;
        model_reset();
        #1;
        check("por_status", gpio_status, 16'hFFFF);
        check("por_write", gpio_write, 16'h0000);
        check("por_irq", {15'b0, irq}, 16'h0000);
        check("por_rvalid", {15'b0, reg_rvalid}, 16'h0000);
        check("por_rdata", reg_rdata, 16'h0000);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Register map table
        for (int i = 0; i < 17; i++) begin
            bus_op(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            check($sformatf("tbl%0d_write", i), gpio_write, vecs[i].exp_write);
            check($sformatf("tbl%0d_status", i), gpio_status, vecs[i].exp_status);
            if (vecs[i].rd) begin
                check($sformatf("tbl%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
                check($sformatf("tbl%0d_rvalid", i), {15'b0, reg_rvalid}, 16'h0001);
            end
        end
        bus_op(1'b1, 1'b0, 3'd3, 16'h0000);
        bus_op(1'b1, 1'b0, 3'd4, 16'h0000);

        // Mid-run reset with pins driven, irq high and a read in flight; pad bit 0 held high across it
        bus_op(1'b1, 1'b0, 3'd1, 16'h0000);
        bus_op(1'b1, 1'b0, 3'd0, 16'hA5A5);
        bus_op(1'b1, 1'b0, 3'd3, 16'h0001);
        settle(16'h0001);
        check("pre_rst_irq", {15'b0, irq}, 16'h0001);
        bus_op(1'b0, 1'b1, 3'd0, '0);
        rst = 1'b1;
        #2;
        check("rst_status", gpio_status, 16'hFFFF);
        check("rst_write", gpio_write, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_rvalid", {15'b0, reg_rvalid}, 16'h0000);
        model_reset();
        tick(); tick();
        rst = 1'b0;
        bus_op(1'b1, 1'b0, 3'd3, 16'h0001);          // edge 1 after release
        read_expect("post_rst_dout", 3'd0, 16'h0000); // edge 2
        read_expect("post_rst_tri", 3'd1, 16'hFFFF);  // edge 3: held-high pad sets IRQ_STAT
        read_expect("post_rst_stat", 3'd5, 16'h0001);
        read_expect("post_rst_din", 3'd2, 16'h0001);
        read_expect("post_rst_fall", 3'd4, 16'h0000);
        bus_op(1'b1, 1'b0, 3'd3, 16'h0000);
        bus_op(1'b1, 1'b0, 3'd5, 16'hFFFF);

        // Input synchronizer latency
        settle(16'h0000);
        gpio_read = 16'h8001;
        tick();                                       // edge N
        read_expect("din_n1", 3'd2, 16'h0000);        // sampled at N+1
        read_expect("din_n2", 3'd2, 16'h8001);        // sampled at N+2

        // Rising-edge interrupt and W1C
        bus_op(1'b1, 1'b0, 3'd3, 16'h0001);
        settle(16'h8000);
        bus_op(1'b1, 1'b0, 3'd5, 16'hFFFF);
        gpio_read = 16'h8001;
        tick(); tick(); tick();                       // N, N+1, N+2
        check("rise_irq_n2", {15'b0, irq}, 16'h0000);
        read_expect("rise_stat", 3'd5, 16'h0001);     // N+3
        check("rise_irq_n3", {15'b0, irq}, 16'h0001);
        bus_op(1'b1, 1'b0, 3'd5, 16'h0001);
        check("w1c_irq_m", {15'b0, irq}, 16'h0001);
        tick();
        check("w1c_irq_m1", {15'b0, irq}, 16'h0000);

        // Fall enable on bit 15 only; a simultaneous bit-0 rise is masked
        bus_op(1'b1, 1'b0, 3'd3, 16'h0000);
        bus_op(1'b1, 1'b0, 3'd4, 16'h8000);
        settle(16'h8000);
        bus_op(1'b1, 1'b0, 3'd5, 16'hFFFF);
        settle(16'h0001);
        read_expect("mask_stat", 3'd5, 16'h8000);

        // Disabling the enable keeps the latched bit
        bus_op(1'b1, 1'b0, 3'd4, 16'h0000);
        read_expect("keep_stat", 3'd5, 16'h8000);

        // W1C colliding with a new bit-0 rise
        bus_op(1'b1, 1'b0, 3'd5, 16'hFFFF);
        bus_op(1'b1, 1'b0, 3'd3, 16'h0001);
        settle(16'h0000);
        settle(16'h0001);
        settle(16'h0000);
        check("coll_pre_irq", {15'b0, irq}, 16'h0001);
        gpio_read = 16'h0001;
        tick(); tick();                               // N, N+1
        bus_op(1'b1, 1'b0, 3'd5, 16'h0001);           // N+2: clear meets new rise
        check("coll_irq", {15'b0, irq}, 16'h0001);
        read_expect("coll_stat", 3'd5, 16'h0001);
        check("coll_irq2", {15'b0, irq}, 16'h0001);

        // Randomized traffic, optionally looping driven pins back onto the pad
        ext = '0;
        loopback = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) loopback = ~loopback;
            if ($urandom_range(0, 7) == 0) ext = 16'($urandom);
            gpio_read = loopback ? ((m_dout & ~m_tri) | (ext & m_tri)) : ext;
            reg_wr    = ($urandom_range(0, 3) == 0);
            reg_rd    = ($urandom_range(0, 2) == 0);
            reg_addr  = 3'($urandom_range(0, 7));
            reg_wdata = 16'($urandom);
            tick();
        end
        reg_wr = 1'b0; reg_rd = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
